pipe_ctrl: RTL and testbench

- Central sequencing controller for the 8-bit four-stage pipeline (IF, ID, EX, WB).
- Drives enable and flush for the IF_ID, ID_EX and EX_WB pipeline registers and the PC.
- Runs the run/halt/single-step state machine and generates operand forwarding selects from the ID_EX and EX_WB register contents.
- Keeps a saturating count of retired register writes.

---
 rtl/pipe_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the 8-bit IF/ID/EX/WB pipeline.
// It runs the flush / run / drain / halted / single-step state machine,
// drives the enable and flush strobes of the PC and of the IF_ID, ID_EX
// and EX_WB registers, produces operand forwarding selects, and keeps a
// saturating count of retired register writes.
// Ports:
//   clk, reset (async, active low)
//   halt_req (level), resume / step_req (pulses, honoured only in HALTED)
//   if_id_instr, id_ex_instr/id_ex_regwrite, ex_wb_instr/ex_wb_regwrite
//   pc_en, *_en, *_flush  pipeline strobes (flush beats en downstream)
//   fwd_a, fwd_b          00 regfile, 01 EX ALUOut, 10 WB ALUOut
//   halted, retired       status
module pipe_ctrl #(
  parameter int         FLUSH_CYCLES = 3,
  parameter int         DRAIN_CYCLES = 2,
  parameter logic [3:0] HALT_OP      = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        step_req,
  input  logic [7:0]  if_id_instr,
  input  logic [7:0]  id_ex_instr,
  input  logic        id_ex_regwrite,
  input  logic [7:0]  ex_wb_instr,
  input  logic        ex_wb_regwrite,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_wb_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {S_FLUSH, S_RUN, S_DRAIN, S_HALTED, S_STEP} state_e;

  state_e      state_q, state_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic        skip_q, skip_d;   // ignore a HALT already sitting in ID
  logic        pend_q, pend_d;   // halt_req seen while flushing
  logic        wb_new_q;         // WB register was loaded on the last edge
  logic [15:0] retired_q, retired_d;
  logic        halt_det;

  // Only the rd fields of the EX/WB instructions feed forwarding.
  logic unused_bits;
  assign unused_bits = ^{id_ex_instr[7:4], id_ex_instr[1:0],
                         ex_wb_instr[7:4], ex_wb_instr[1:0]};

  assign halt_det = (state_q == S_RUN) && (if_id_instr[7:4] == HALT_OP) && !skip_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FLUSH;
      fcnt_q    <= '0;
      dcnt_q    <= '0;
      skip_q    <= 1'b0;
      pend_q    <= 1'b0;
      wb_new_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      dcnt_q    <= dcnt_d;
      skip_q    <= skip_d;
      pend_q    <= pend_d;
      wb_new_q  <= ex_wb_en;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    dcnt_d  = '0;          // drain counter restarts on every DRAIN entry
    skip_d  = skip_q;
    pend_d  = 1'b0;
    unique case (state_q)
      S_FLUSH: begin
        pend_d = pend_q | halt_req;
        fcnt_d = fcnt_q + 16'd1;
        if (fcnt_q == 16'(FLUSH_CYCLES - 1))
          state_d = (pend_q | halt_req) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        skip_d = 1'b0;
        if (halt_det || halt_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 16'd1;
        if (dcnt_q == 16'(DRAIN_CYCLES - 1)) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (resume) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end else if (step_req) begin
          state_d = S_STEP;
          skip_d  = 1'b1;
        end
      end
      S_STEP: begin
        skip_d  = 1'b0;
        state_d = S_HALTED;
      end
      default: state_d = S_FLUSH;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_wb_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_wb_flush = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        ex_wb_flush = 1'b1;
      end
      S_RUN, S_STEP: begin
        // A HALT in ID freezes fetch in the very cycle it is decoded.
        pc_en       = !halt_det;
        if_id_en    = !halt_det;
        id_ex_en    = 1'b1;
        ex_wb_en    = 1'b1;
        id_ex_flush = halt_det;
      end
      S_DRAIN: begin
        id_ex_en    = 1'b1;
        ex_wb_en    = 1'b1;
        id_ex_flush = 1'b1;
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  function automatic logic [1:0] fwd_sel(input logic [1:0] rs,
                                         input logic ex_rw, input logic [1:0] ex_rd,
                                         input logic wb_rw, input logic [1:0] wb_rd);
    if (ex_rw && ex_rd == rs)      return 2'b01;
    else if (wb_rw && wb_rd == rs) return 2'b10;
    else                           return 2'b00;
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (state_q != S_FLUSH) begin
      fwd_a = fwd_sel(if_id_instr[3:2], id_ex_regwrite, id_ex_instr[3:2],
                      ex_wb_regwrite, ex_wb_instr[3:2]);
      fwd_b = fwd_sel(if_id_instr[1:0], id_ex_regwrite, id_ex_instr[3:2],
                      ex_wb_regwrite, ex_wb_instr[3:2]);
    end
  end

  // wb_new gates the count so an instruction frozen in WB counts once.
  always_comb begin
    retired_d = retired_q;
    if (ex_wb_regwrite && wb_new_q && retired_q != 16'hFFFF)
      retired_d = retired_q + 16'd1;
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halt_req = 1'b0, resume = 1'b0, step_req = 1'b0;
  logic [7:0]  if_id_instr = 8'h00, id_ex_instr = 8'h00, ex_wb_instr = 8'h00;
  logic        id_ex_regwrite = 1'b0, ex_wb_regwrite = 1'b0;
  logic        pc_en, if_id_en, id_ex_en, ex_wb_en;
  logic        if_id_flush, id_ex_flush, ex_wb_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        halted;
  logic [15:0] retired;

  int checks = 0;
  int failures = 0;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .halt_req(halt_req), .resume(resume),
    .step_req(step_req), .if_id_instr(if_id_instr), .id_ex_instr(id_ex_instr),
    .id_ex_regwrite(id_ex_regwrite), .ex_wb_instr(ex_wb_instr),
    .ex_wb_regwrite(ex_wb_regwrite), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_wb_en(ex_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_wb_flush(ex_wb_flush), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [3:0] en_o;
  logic [2:0] fl_o;
  assign en_o = {pc_en, if_id_en, id_ex_en, ex_wb_en};
  assign fl_o = {if_id_flush, id_ex_flush, ex_wb_flush};

  typedef struct {
    logic        hr, rs, st;
    logic [7:0]  ii, xi;
    logic        xr;
    logic [7:0]  wi;
    logic        wr;
    logic [3:0]  en;
    logic [2:0]  fl;
    logic [1:0]  fa, fb;
    logic        h;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(logic hr, logic rs, logic st, logic [7:0] ii,
                              logic [7:0] xi, logic xr, logic [7:0] wi, logic wr,
                              logic [3:0] en, logic [2:0] fl, logic [1:0] fa,
                              logic [1:0] fb, logic h, logic [15:0] ret);
    vec_t v;
    v.hr = hr; v.rs = rs; v.st = st; v.ii = ii; v.xi = xi; v.xr = xr;
    v.wi = wi; v.wr = wr; v.en = en; v.fl = fl; v.fa = fa; v.fb = fb;
    v.h = h; v.ret = ret;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Called on a falling edge; returns on a falling edge.
  task automatic wait_halted(input string nm);
    int n = 0;
    while (!halted && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    //            hr rs st ii     xi     xr wi     wr en       fl      fa fb h  ret
    tbl[0]  = mk(0, 0, 0, 8'h16, 8'h24, 1, 8'h38, 1, 4'b0000, 3'b111, 0, 0, 0, 0); // FLUSH, fwd forced 00
    tbl[1]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'b0000, 3'b111, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'b0000, 3'b111, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'b1111, 3'b000, 0, 0, 0, 0); // RUN
    tbl[4]  = mk(0, 0, 0, 8'h16, 8'h24, 1, 8'h38, 1, 4'b1111, 3'b000, 1, 2, 0, 0); // EX->a, WB->b
    tbl[5]  = mk(0, 0, 0, 8'h16, 8'h24, 0, 8'h38, 1, 4'b1111, 3'b000, 0, 2, 0, 1);
    tbl[6]  = mk(0, 0, 0, 8'h05, 8'h04, 1, 8'h04, 1, 4'b1111, 3'b000, 1, 1, 0, 2); // EX beats WB
    tbl[7]  = mk(0, 0, 0, 8'h0B, 8'h08, 1, 8'h00, 0, 4'b1111, 3'b000, 1, 0, 0, 3);
    tbl[8]  = mk(0, 0, 0, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b0011, 3'b010, 0, 0, 0, 3); // HALT in ID
    tbl[9]  = mk(0, 0, 0, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b0011, 3'b010, 0, 0, 0, 3); // DRAIN
    tbl[10] = mk(0, 0, 0, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b0011, 3'b010, 0, 0, 0, 3); // DRAIN
    tbl[11] = mk(0, 0, 0, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b0000, 3'b000, 0, 0, 1, 3); // HALTED
    tbl[12] = mk(0, 1, 0, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b0000, 3'b000, 0, 0, 1, 3); // resume
    tbl[13] = mk(0, 0, 0, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b1111, 3'b000, 0, 0, 0, 3); // HALT skipped
    tbl[14] = mk(0, 1, 1, 8'h00, 8'h00, 0, 8'h00, 0, 4'b1111, 3'b000, 0, 0, 0, 3); // pulses ignored
    tbl[15] = mk(0, 0, 0, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b0011, 3'b010, 0, 0, 0, 3); // skip cleared
    tbl[16] = mk(0, 0, 0, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b0011, 3'b010, 0, 0, 0, 3);
    tbl[17] = mk(0, 0, 0, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b0011, 3'b010, 0, 0, 0, 3);
    tbl[18] = mk(0, 0, 0, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b0000, 3'b000, 0, 0, 1, 3);
    tbl[19] = mk(0, 0, 1, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b0000, 3'b000, 0, 0, 1, 3); // step_req
    tbl[20] = mk(0, 0, 0, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b1111, 3'b000, 0, 0, 0, 3); // STEP
    tbl[21] = mk(0, 1, 1, 8'hF0, 8'h00, 0, 8'h00, 0, 4'b0000, 3'b000, 0, 0, 1, 3); // both: resume wins
    tbl[22] = mk(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'b1111, 3'b000, 0, 0, 0, 3); // RUN, halt_req
    tbl[23] = mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'b0011, 3'b010, 0, 0, 0, 3);
    tbl[24] = mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'b0011, 3'b010, 0, 0, 0, 3);
    tbl[25] = mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 4'b0000, 3'b000, 0, 0, 1, 3);

    // Reset held low: forwarding inputs are live but must be masked.
    if_id_instr = 8'h16; id_ex_instr = 8'h24; id_ex_regwrite = 1'b1;
    ex_wb_instr = 8'h38; ex_wb_regwrite = 1'b1;
    @(negedge clk);
    #2;
    chk("rst_en", {28'd0, en_o}, 32'h0);
    chk("rst_flush", {29'd0, fl_o}, 32'h7);
    chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 26; i++) begin
      halt_req = tbl[i].hr; resume = tbl[i].rs; step_req = tbl[i].st;
      if_id_instr = tbl[i].ii; id_ex_instr = tbl[i].xi; id_ex_regwrite = tbl[i].xr;
      ex_wb_instr = tbl[i].wi; ex_wb_regwrite = tbl[i].wr;
      #2;
      chk($sformatf("v%0d_en", i), {28'd0, en_o}, {28'd0, tbl[i].en});
      chk($sformatf("v%0d_flush", i), {29'd0, fl_o}, {29'd0, tbl[i].fl});
      chk($sformatf("v%0d_fwd_a", i), {30'd0, fwd_a}, {30'd0, tbl[i].fa});
      chk($sformatf("v%0d_fwd_b", i), {30'd0, fwd_b}, {30'd0, tbl[i].fb});
      chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].h});
      chk($sformatf("v%0d_retired", i), {16'd0, retired}, {16'd0, tbl[i].ret});
      @(negedge clk);
    end

    // Reset in RUN, then halt_req during FLUSH diverts the exit to DRAIN.
    halt_req = 1'b0; resume = 1'b0; step_req = 1'b0; if_id_instr = 8'h00;
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_en", {28'd0, en_o}, 32'h0);
    chk("midrst_flush", {29'd0, fl_o}, 32'h7);
    chk("midrst_retired", {16'd0, retired}, 32'd0);
    @(negedge clk);
    reset = 1'b1; halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    @(negedge clk);
    #2;
    chk("pend_flush3", {29'd0, fl_o}, 32'h7);
    @(negedge clk);
    #2;
    chk("pend_drain_en", {28'd0, en_o}, 32'h3);
    chk("pend_drain_fl", {29'd0, fl_o}, 32'h2);
    @(negedge clk);
    wait_halted("pend_halted");

    // Five consecutive WB writes.
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    @(negedge clk);
    ex_wb_regwrite = 1'b1;
    repeat (5) @(negedge clk);
    ex_wb_regwrite = 1'b0;
    #2;
    chk("retire5", {16'd0, retired}, 32'd5);

    // A write frozen in WB while halted is not recounted.
    @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    wait_halted("hold_halted");
    @(negedge clk);
    ex_wb_regwrite = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    chk("retire_frozen", {16'd0, retired}, 32'd5);

    // Saturation.
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    repeat (65540) @(negedge clk);
    #2;
    chk("retire_sat", {16'd0, retired}, 32'hFFFF);
    @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    wait_halted("sat_halted");
    ex_wb_regwrite = 1'b0;
    chk("retire_sat_hold", {16'd0, retired}, 32'hFFFF);

    // halt_req still high on resume: one RUN cycle, then DRAIN again.
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    #2;
    chk("rehalt_run_pc", {31'd0, pc_en}, 32'd1);
    chk("rehalt_run_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    #2;
    chk("rehalt_drain_pc", {31'd0, pc_en}, 32'd0);
    chk("rehalt_drain_fl", {31'd0, id_ex_flush}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
